// File: rtl/vector_sweeper_pkg.sv
// Shared constants and FSM state type for the six-input vector sweeper.
package vector_sweeper_pkg;

    localparam int NVEC   = 64;
    localparam int IDX_W  = 6;
    localparam int ONES_W = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/vector_sweeper_settle.sv
// Settle timer: counts cycles a vector is held and flags the last one.
module settle_timer #(
    parameter int SETTLE = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic enable,
    output logic last
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    assign last = enable && !clear && (count_q == 8'(SETTLE - 1));

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = last ? 8'd0 : count_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vector_sweeper.sv
// Walks all 64 input vectors through a six-input gate network and captures
// the sampled response per vector, plus a running count of ones.
module vector_sweeper
    import vector_sweeper_pkg::*;
#(
    parameter int SETTLE = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              Y,
    output logic              A,
    output logic              B,
    output logic              C,
    output logic              D,
    output logic              E,
    output logic              F,
    output logic              BUSY,
    output logic              DONE,
    output logic [NVEC-1:0]   RESULT,
    output logic [ONES_W-1:0] ONES
);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    vec_q, vec_d;
    logic [NVEC-1:0]     result_q, result_d;
    logic [ONES_W-1:0]   ones_q, ones_d;
    logic                start_ok;
    logic                last;

    assign start_ok = START && (state_q != RUN);

    settle_timer #(
        .SETTLE(SETTLE)
    ) u_settle (
        .CLK    (CLK),
        .RST    (RST),
        .clear  (start_ok),
        .enable (state_q == RUN),
        .last   (last)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        result_d = result_q;
        ones_d   = ones_q;
        case (state_q)
            IDLE, FIN: begin
                if (START) begin
                    state_d  = RUN;
                    idx_d    = '0;
                    result_d = '0;
                    ones_d   = '0;
                end
            end
            RUN: begin
                // Y is only looked at on the final settle cycle of a vector.
                if (last) begin
                    result_d[idx_q] = Y;
                    ones_d          = ones_q + {{(ONES_W-1){1'b0}}, Y};
                    if (idx_q == IDX_W'(NVEC - 1)) begin
                        state_d = FIN;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Stimulus register tracks the next index so A..F change on the same edge as idx.
        vec_d = (state_d == RUN) ? idx_d : '0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            vec_q    <= '0;
            result_q <= '0;
            ones_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            vec_q    <= vec_d;
            result_q <= result_d;
            ones_q   <= ones_d;
        end
    end

    assign {A, B, C, D, E, F} = vec_q;
    assign BUSY   = (state_q == RUN);
    assign DONE   = (state_q == FIN);
    assign RESULT = result_q;
    assign ONES   = ones_q;

endmodule

// File: tb/tb_vector_sweeper.sv
// Bench for vector_sweeper: two instances (SETTLE=4 and SETTLE=1) driven by
// a table of sweep scenarios and checked against a cycle-count reference model.
module tb_vector_sweeper;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start4 = 1'b0, start1 = 1'b0;
    logic        y4, y1;
    logic        a4, b4, c4, d4, e4, f4;
    logic        a1, b1, c1, d1, e1, f1;
    logic        busy4, done4, busy1, done1;
    logic [63:0] result4, result1;
    logic [6:0]  ones4, ones1;

    int          mode_v = 0;   // 0 gate network, 1 tied high, 2 tied low, 3 random
    logic        yrand = 1'b0;
    int          sel = 0;      // 0 -> SETTLE=4 instance, 1 -> SETTLE=1 instance
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 CLK = ~CLK;

    vector_sweeper #(.SETTLE(4)) u_dut4 (
        .CLK(CLK), .RST(RST), .START(start4), .Y(y4),
        .A(a4), .B(b4), .C(c4), .D(d4), .E(e4), .F(f4),
        .BUSY(busy4), .DONE(done4), .RESULT(result4), .ONES(ones4)
    );

    vector_sweeper #(.SETTLE(1)) u_dut1 (
        .CLK(CLK), .RST(RST), .START(start1), .Y(y1),
        .A(a1), .B(b1), .C(c1), .D(d1), .E(e1), .F(f1),
        .BUSY(busy1), .DONE(done1), .RESULT(result1), .ONES(ones1)
    );

    function automatic logic gate_net(input logic a, b, c, d, e, f);
        return ~(~(a & b) & (c & ~b & d) & ~(e | f));
    endfunction

    function automatic logic ysel(input int m, input logic g, input logic r);
        case (m)
            0:       return g;
            1:       return 1'b1;
            2:       return 1'b0;
            default: return r;
        endcase
    endfunction

    always_comb y4 = ysel(mode_v, gate_net(a4, b4, c4, d4, e4, f4), yrand);
    always_comb y1 = ysel(mode_v, gate_net(a1, b1, c1, d1, e1, f1), yrand);

    logic        busy_s, done_s, y_s;
    logic [5:0]  vec_s;
    logic [63:0] result_s;
    logic [6:0]  ones_s;
    always_comb begin
        busy_s   = sel ? busy1   : busy4;
        done_s   = sel ? done1   : done4;
        y_s      = sel ? y1      : y4;
        vec_s    = sel ? {a1, b1, c1, d1, e1, f1} : {a4, b4, c4, d4, e4, f4};
        result_s = sel ? result1 : result4;
        ones_s   = sel ? ones1   : ones4;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel != 0) start1 = v; else start4 = v;
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy_s), 64'd0);
        chk({tag, "_done"}, 64'(done_s), 64'd0);
        chk({tag, "_vec"}, 64'(vec_s), 64'd0);
        chk({tag, "_result"}, result_s, 64'd0);
        chk({tag, "_ones"}, 64'(ones_s), 64'd0);
    endtask

    // Reference: after edge k of a sweep the vector shown is k/SETTLE; the Y
    // present just before edge k is captured when k is a multiple of SETTLE.
    task automatic sweep(input int settle, input int restart_at, input int rst_at,
                         output logic [63:0] exp_res, output int exp_ones, output bit aborted);
        logic y_now;
        int   total;
        total    = 64 * settle;
        exp_res  = '0;
        exp_ones = 0;
        aborted  = 1'b0;
        @(negedge CLK);
        set_start(1'b1);
        @(posedge CLK);
        #1;
        set_start(1'b0);
        chk("accept_busy", 64'(busy_s), 64'd1);
        chk("accept_done", 64'(done_s), 64'd0);
        chk("accept_result", result_s, 64'd0);
        chk("accept_ones", 64'(ones_s), 64'd0);
        for (int k = 1; k <= total; k++) begin
            @(negedge CLK);
            set_start(k == restart_at);
            yrand = 1'($urandom);
            #1;
            y_now = y_s;
            @(posedge CLK);
            if (k % settle == 0) begin
                exp_res[k / settle - 1] = y_now;
                exp_ones += int'(y_now);
            end
            #1;
            if (k == rst_at) begin
                RST = 1'b1;
                #1;
                check_idle_zero("async_rst");
                #1;
                RST = 1'b0;
                aborted = 1'b1;
                return;
            end
            if (k < total) begin
                chk("run_busy", 64'(busy_s), 64'd1);
                chk("run_done", 64'(done_s), 64'd0);
                chk("run_vec", 64'(vec_s), 64'(k / settle));
            end else begin
                chk("fin_busy", 64'(busy_s), 64'd0);
                chk("fin_done", 64'(done_s), 64'd1);
                chk("fin_vec", 64'(vec_s), 64'd0);
                chk("fin_result", result_s, exp_res);
                chk("fin_ones", 64'(ones_s), 64'(exp_ones));
            end
        end
        set_start(1'b0);
        // FIN must hold its result while Y keeps moving.
        for (int h = 0; h < 3; h++) begin
            @(negedge CLK);
            yrand = 1'($urandom);
            @(posedge CLK);
            #1;
            chk("hold_done", 64'(done_s), 64'd1);
            chk("hold_result", result_s, exp_res);
            chk("hold_ones", 64'(ones_s), 64'(exp_ones));
        end
    endtask

    typedef struct {
        int          s_sel;
        int          mode;
        int          restart_at;
        int          rst_at;
        logic [63:0] exp_res;
        int          exp_ones;
        bit          use_exp;
    } sweep_vec_t;

    localparam logic [63:0] GATE_RES = 64'hFFFF_EFFF_FFFF_EFFF;

    sweep_vec_t tbl[10];

    initial begin
        logic [63:0] m_res;
        int          m_ones;
        bit          ab;

        tbl[0] = '{0, 0,  -1,  -1, GATE_RES,     62, 1'b1};
        tbl[1] = '{1, 0,  -1,  -1, GATE_RES,     62, 1'b1};
        tbl[2] = '{0, 0, 100,  -1, GATE_RES,     62, 1'b1};
        tbl[3] = '{0, 0,  -1, 130, 64'd0,         0, 1'b0};
        tbl[4] = '{0, 0,  -1,  -1, GATE_RES,     62, 1'b1};
        tbl[5] = '{0, 1,  -1,  -1, {64{1'b1}},   64, 1'b1};
        tbl[6] = '{0, 2,  -1,  -1, 64'd0,         0, 1'b1};
        tbl[7] = '{1, 3,  -1,  -1, 64'd0,         0, 1'b0};
        tbl[8] = '{0, 3,  -1,  -1, 64'd0,         0, 1'b0};
        tbl[9] = '{1, 1,  -1,  -1, {64{1'b1}},   64, 1'b1};

        #1;
        sel = 0; check_idle_zero("reset4");
        sel = 1; check_idle_zero("reset1");
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < 10; i++) begin
            sel    = tbl[i].s_sel;
            mode_v = tbl[i].mode;
            sweep(sel ? 1 : 4, tbl[i].restart_at, tbl[i].rst_at, m_res, m_ones, ab);
            if (ab) begin
                // After an aborted sweep nothing may start without a new START.
                for (int h = 0; h < 4; h++) begin
                    @(posedge CLK);
                    #1;
                    check_idle_zero("post_rst_idle");
                end
                $display("sweep %0d settle=%0d mode=%0d aborted by reset", i, sel ? 1 : 4, mode_v);
            end else begin
                if (tbl[i].use_exp) begin
                    chk("tbl_result", result_s, tbl[i].exp_res);
                    chk("tbl_ones", 64'(ones_s), 64'(tbl[i].exp_ones));
                end
                $display("sweep %0d settle=%0d mode=%0d result=%h ones=%0d", i, sel ? 1 : 4,
                         mode_v, result_s, ones_s);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
